// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter that shares one single-byte SPI master between
// NUM_REQ requesters. It runs one transfer per grant, tracks completion
// through the master's chip select and returns the received byte, or an
// error flag when a watchdog aborts a stalled transfer.
module spi_request_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic                          busy,
    output logic                          spi_enable,
    output logic [DATA_WIDTH-1:0]         spi_data_in,
    input  logic                          spi_cs,
    input  logic [DATA_WIDTH-1:0]         spi_data_out
);

    localparam int PTR_W   = $clog2(NUM_REQ);
    // One extra bit so the counter can never wrap before it reaches expiry.
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_LOW,
        ST_WAIT_HIGH
    } state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  busy_q, busy_d;
    logic                  spi_enable_q, spi_enable_d;
    logic [DATA_WIDTH-1:0] spi_data_in_q, spi_data_in_d;

    logic                  hi_found, any_found;
    logic [PTR_W-1:0]      hi_idx, any_idx, win_idx;
    logic [DATA_WIDTH-1:0] hi_data, any_data, win_data;
    logic [NUM_REQ-1:0]    win_oh, owner_oh;
    logic                  timer_expired;

    // Round-robin pick: lowest requester above the pointer, else lowest overall.
    always_comb begin
        hi_found  = 1'b0;
        any_found = 1'b0;
        hi_idx    = '0;
        any_idx   = '0;
        hi_data   = '0;
        any_data  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_found = 1'b1;
                any_idx   = PTR_W'(i);
                any_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (req[i] && (PTR_W'(i) > ptr_q)) begin
                hi_found = 1'b1;
                hi_idx   = PTR_W'(i);
                hi_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        win_idx  = hi_found ? hi_idx : any_idx;
        win_data = hi_found ? hi_data : any_data;
        win_oh   = '0;
        owner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_oh[i]   = (PTR_W'(i) == win_idx);
            owner_oh[i] = (PTR_W'(i) == ptr_q);
        end
    end

    assign timer_expired = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    // Transfer sequencing, watchdog and next values of every registered output.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        timer_d       = timer_q;
        gnt_d         = '0;
        rsp_valid_d   = '0;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        spi_enable_d  = spi_enable_q;
        spi_data_in_d = spi_data_in_q;

        case (state_q)
            ST_IDLE: begin
                if (any_found) begin
                    gnt_d         = win_oh;
                    spi_data_in_d = win_data;
                    ptr_d         = win_idx;
                    spi_enable_d  = 1'b1;
                    timer_d       = '0;
                    state_d       = ST_START;
                end
            end
            ST_START: begin
                timer_d = timer_q + TIMER_W'(1);
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!spi_cs) begin
                    spi_enable_d = 1'b0;
                    timer_d      = '0;
                    state_d      = ST_WAIT_HIGH;
                end else if (timer_expired) begin
                    spi_enable_d = 1'b0;
                    rsp_valid_d  = owner_oh;
                    rsp_err_d    = 1'b1;
                    rsp_data_d   = '0;
                    state_d      = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (spi_cs) begin
                    rsp_data_d  = spi_data_out;
                    rsp_valid_d = owner_oh;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else if (timer_expired) begin
                    spi_enable_d = 1'b0;
                    rsp_valid_d  = owner_oh;
                    rsp_err_d    = 1'b1;
                    rsp_data_d   = '0;
                    state_d      = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= PTR_W'(NUM_REQ - 1);
            timer_q       <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            spi_enable_q  <= 1'b0;
            spi_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            timer_q       <= timer_d;
            gnt_q         <= gnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            busy_q        <= busy_d;
            spi_enable_q  <= spi_enable_d;
            spi_data_in_q <= spi_data_in_d;
        end
    end

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;
    assign spi_enable  = spi_enable_q;
    assign spi_data_in = spi_data_in_q;

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Directed bench for spi_request_arbiter with a small behavioural SPI master
// that answers spi_enable with a programmable chip-select low/high timing.
module tb_spi_request_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
    localparam int TMO     = 16;

    logic                   clk;
    logic                   reset;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ*DW-1:0]  req_data;
    logic [NUM_REQ-1:0]     gnt;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [DW-1:0]          rsp_data;
    logic                   rsp_err;
    logic                   busy;
    logic                   spi_enable;
    logic [DW-1:0]          spi_data_in;
    logic                   spi_cs;
    logic [DW-1:0]          spi_data_out;

    int total_checks = 0;
    int bad_checks   = 0;

    // Behavioural master controls
    logic    slave_stall   = 1'b0;
    int      cs_low_delay  = 1;
    int      cs_high_delay = 2;
    logic [DW-1:0] slave_echo = 8'h00;

    spi_request_arbiter #(
        .NUM_REQ(NUM_REQ),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .rsp_valid(rsp_valid),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .busy(busy),
        .spi_enable(spi_enable),
        .spi_data_in(spi_data_in),
        .spi_cs(spi_cs),
        .spi_data_out(spi_data_out)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Master model: after seeing spi_enable, pull cs low then release it with data
    initial begin
        spi_cs       = 1'b1;
        spi_data_out = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!slave_stall && spi_enable && spi_cs) begin
                repeat (cs_low_delay) @(posedge clk);
                #1 spi_cs = 1'b0;
                repeat (cs_high_delay) @(posedge clk);
                #1;
                spi_data_out = slave_echo;
                spi_cs       = 1'b1;
            end
        end
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete, got hang expected finish");
        $fatal(1, "[TB] aborted");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*DW-1:0] d);
        req      = r;
        req_data = d;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        req   = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic waitResponse(input int max_cycles, output logic seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        for (int c = 1; c <= max_cycles && !seen; c++) begin
            step();
            if (|rsp_valid) begin
                seen   = 1'b1;
                cycles = c;
            end
        end
    endtask

    logic          seen;
    int            cycles;
    int            gnt_count;
    int            rsp_count;
    logic [NUM_REQ-1:0] exp_oh;
    logic [DW-1:0] t2_bytes [NUM_REQ];

    initial begin
        t2_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        reset    = 1'b1;
        req      = '0;
        req_data = '0;
        step();
        step();

        // Reset state
        checkOutput("rst_gnt",         32'(gnt), 32'h0);
        checkOutput("rst_rsp_valid",   32'(rsp_valid), 32'h0);
        checkOutput("rst_rsp_data",    32'(rsp_data), 32'h0);
        checkOutput("rst_rsp_err",     32'(rsp_err), 32'h0);
        checkOutput("rst_busy",        32'(busy), 32'h0);
        checkOutput("rst_spi_enable",  32'(spi_enable), 32'h0);
        checkOutput("rst_spi_data_in", 32'(spi_data_in), 32'h0);
        reset = 1'b0;
        step();

        // 1: single request, echo 3C
        slave_echo = 8'h3C;
        applyStimulus(4'b0001, 32'h0000_00A5);
        step();
        checkOutput("t1_gnt",         32'(gnt), 32'h1);
        checkOutput("t1_spi_data_in", 32'(spi_data_in), 32'hA5);
        checkOutput("t1_spi_enable",  32'(spi_enable), 32'h1);
        checkOutput("t1_busy",        32'(busy), 32'h1);
        req = '0;
        waitResponse(40, seen, cycles);
        checkOutput("t1_rsp_seen",  32'(seen), 32'h1);
        checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t1_rsp_data",  32'(rsp_data), 32'h3C);
        checkOutput("t1_rsp_err",   32'(rsp_err), 32'h0);
        step();
        checkOutput("t1_rsp_pulse", 32'(rsp_valid), 32'h0);

        // 2: all four held, pointer restarted by reset -> order 0,1,2,3,0,1,2,3
        resetDut();
        slave_echo = 8'h5A;
        applyStimulus(4'b1111, {t2_bytes[3], t2_bytes[2], t2_bytes[1], t2_bytes[0]});
        for (int t = 0; t < 8; t++) begin
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                step();
                if (|rsp_valid) begin
                    checkOutput("t2_rsp_valid", 32'(rsp_valid), 32'(1 << ((t + 3) % 4)));
                    checkOutput("t2_rsp_data",  32'(rsp_data), 32'h5A);
                end
                if (|gnt) seen = 1'b1;
            end
            checkOutput("t2_gnt_seen", 32'(seen), 32'h1);
            checkOutput("t2_gnt_order", 32'(gnt), 32'(1 << (t % 4)));
            checkOutput("t2_data_in", 32'(spi_data_in), 32'(t2_bytes[t % 4]));
            if (t == 7) req = '0;
        end
        waitResponse(40, seen, cycles);
        checkOutput("t2_last_rsp", 32'(rsp_valid), 32'h8);

        // 3: master stalls with cs high -> abort 16 cycles after grant
        slave_stall = 1'b1;
        step();
        applyStimulus(4'b0010, 32'h0000_7700);
        step();
        checkOutput("t3_gnt", 32'(gnt), 32'h2);
        req = '0;
        waitResponse(40, seen, cycles);
        checkOutput("t3_cycles",     32'(cycles), 32'd16);
        checkOutput("t3_rsp_valid",  32'(rsp_valid), 32'h2);
        checkOutput("t3_rsp_err",    32'(rsp_err), 32'h1);
        checkOutput("t3_rsp_data",   32'(rsp_data), 32'h0);
        checkOutput("t3_spi_enable", 32'(spi_enable), 32'h0);
        checkOutput("t3_busy",       32'(busy), 32'h0);
        step();
        checkOutput("t3_busy_next",  32'(busy), 32'h0);
        checkOutput("t3_rsp_pulse",  32'(rsp_valid), 32'h0);
        slave_stall = 1'b0;
        step();

        // 6a: cs rises exactly on the expiry cycle of WAIT_HIGH -> success
        cs_low_delay  = 1;
        cs_high_delay = 16;
        slave_echo    = 8'hC3;
        applyStimulus(4'b0100, 32'h0099_0000);
        step();
        checkOutput("t6a_gnt", 32'(gnt), 32'h4);
        req = '0;
        waitResponse(40, seen, cycles);
        checkOutput("t6a_cycles",    32'(cycles), 32'd18);
        checkOutput("t6a_rsp_valid", 32'(rsp_valid), 32'h4);
        checkOutput("t6a_rsp_err",   32'(rsp_err), 32'h0);
        checkOutput("t6a_rsp_data",  32'(rsp_data), 32'hC3);
        repeat (3) step();

        // 6b: cs one cycle too late -> timeout in WAIT_HIGH
        cs_high_delay = 17;
        slave_echo    = 8'hE7;
        applyStimulus(4'b0100, 32'h0099_0000);
        step();
        checkOutput("t6b_gnt", 32'(gnt), 32'h4);
        req = '0;
        waitResponse(40, seen, cycles);
        checkOutput("t6b_cycles",    32'(cycles), 32'd18);
        checkOutput("t6b_rsp_err",   32'(rsp_err), 32'h1);
        checkOutput("t6b_rsp_data",  32'(rsp_data), 32'h0);
        repeat (4) step();

        // 5: req[1] pulsed for one cycle while requester 0 is served
        cs_high_delay = 2;
        slave_echo    = 8'h96;
        applyStimulus(4'b0001, 32'h0000_0012);
        step();
        checkOutput("t5_gnt", 32'(gnt), 32'h1);
        req = '0;
        step();
        req = 4'b0010;
        step();
        req       = '0;
        gnt_count = 0;
        rsp_count = 0;
        exp_oh    = '0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (|gnt) gnt_count++;
            if (|rsp_valid) begin
                rsp_count++;
                exp_oh = rsp_valid;
            end
        end
        checkOutput("t5_no_gnt",    32'(gnt_count), 32'd0);
        checkOutput("t5_rsp_count", 32'(rsp_count), 32'd1);
        checkOutput("t5_rsp_owner", 32'(exp_oh), 32'h1);

        // 4: reset in WAIT_HIGH, then pointer must restart so 0101 picks 0
        cs_high_delay = 6;
        slave_echo    = 8'h81;
        applyStimulus(4'b0010, 32'h0000_3300);
        step();
        checkOutput("t4_gnt", 32'(gnt), 32'h2);
        req = '0;
        repeat (3) step();
        reset = 1'b1;
        step();
        checkOutput("t4_rst_busy",       32'(busy), 32'h0);
        checkOutput("t4_rst_spi_enable", 32'(spi_enable), 32'h0);
        checkOutput("t4_rst_data_in",    32'(spi_data_in), 32'h0);
        checkOutput("t4_rst_rsp_data",   32'(rsp_data), 32'h0);
        checkOutput("t4_rst_rsp_valid",  32'(rsp_valid), 32'h0);
        reset     = 1'b0;
        rsp_count = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (|rsp_valid) rsp_count++;
        end
        checkOutput("t4_no_rsp", 32'(rsp_count), 32'd0);
        slave_echo = 8'h42;
        applyStimulus(4'b0101, 32'h00AA_00BB);
        step();
        checkOutput("t4_gnt_after_rst", 32'(gnt), 32'h1);
        checkOutput("t4_data_after_rst", 32'(spi_data_in), 32'hBB);
        req = '0;
        waitResponse(40, seen, cycles);
        checkOutput("t4_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t4_rsp_data",  32'(rsp_data), 32'h42);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
